tx_record_scheduler: RTL

Shares the single uart_tx byte channel between three record sources: probe-event records popped from the event FIFO, periodic timestamp heartbeats, and FIFO-overflow drop reports. Each record is framed as a 6-byte packet and serialized one byte per UART handshake. The block sits between the event FIFO / timestamp counter and uart_tx, and replaces ad-hoc byte sequencing in the top level. A "hello\n" banner is sent once after every reset.

---
 rtl/tx_record_scheduler_pkg.sv | 44 ++++
 rtl/tx_record_scheduler_if.sv | 34 +++
 rtl/tx_record_scheduler_hb_timer.sv | 26 ++
 rtl/tx_record_scheduler.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/tx_record_scheduler_pkg.sv
// Shared constants and types for the UART record scheduler.
// Frame headers, banner text, FSM and source enums.
package tx_record_pkg;

  localparam int FRAME_W = 48;

  localparam logic [7:0] HDR_EVENT = 8'hAA;
  localparam logic [7:0] HDR_HB    = 8'hA5;
  localparam logic [7:0] HDR_OVF   = 8'hA0;

  localparam logic [FRAME_W-1:0] BANNER = 48'h68656c6c6f0a;

  typedef enum logic [1:0] {
    IDLE,
    START,
    HOLD,
    DRAIN
  } state_e;

  typedef enum logic [1:0] {
    SRC_BANNER,
    SRC_OVF,
    SRC_HB,
    SRC_EV
  } src_e;

  // Byte idx of a frame, byte 0 being the MSB end.
  function automatic logic [7:0] frame_byte(
    input logic [FRAME_W-1:0] f,
    input logic [2:0]         idx
  );
    logic [7:0] b;
    case (idx)
      3'd0:    b = f[47:40];
      3'd1:    b = f[39:32];
      3'd2:    b = f[31:24];
      3'd3:    b = f[23:16];
      3'd4:    b = f[15:8];
      default: b = f[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tx_record_scheduler_if.sv
// FIFO-side and UART-side handshake bundle.
// master = scheduler, slave = FIFO/UART environment.
interface tx_record_scheduler_if;
  import tx_record_pkg::*;

  logic [39:0] ev_data;
  logic        ev_valid;
  logic        ev_adv;
  logic        ev_drop;
  logic [7:0]  tx_dat;
  logic        tx_start;
  logic        tx_busy;

  modport master (
    input  ev_data,
    input  ev_valid,
    input  ev_drop,
    input  tx_busy,
    output ev_adv,
    output tx_dat,
    output tx_start
  );

  modport slave (
    output ev_data,
    output ev_valid,
    output ev_drop,
    output tx_busy,
    input  ev_adv,
    input  tx_dat,
    input  tx_start
  );

endinterface

// File: rtl/tx_record_scheduler_hb_timer.sv
// Free-running heartbeat interval timer.
// tick pulses for one cycle when the count wraps.
module hb_timer #(
  parameter logic [31:0] HB_PERIOD = 32'd24000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Count 0..HB_PERIOD-1 and wrap.
  always_comb begin
    tick  = (cnt_q == HB_PERIOD - 32'd1);
    cnt_d = tick ? 32'd0 : cnt_q + 32'd1;
  end

  // Counter register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tx_record_scheduler.sv
// Arbitrates banner/overflow/heartbeat/event records
// and serializes each 6-byte frame onto uart_tx.
module tx_record_scheduler
  import tx_record_pkg::*;
#(
  parameter logic [31:0] HB_PERIOD = 32'd24000000,
  parameter int          STAMP_W   = 32,
  parameter int          PROBE_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STAMP_W-1:0] stamp,
  tx_record_scheduler_if.master bus,
  output logic               rec_active,
  output logic [15:0]        drop_count
);

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [7:0]         tx_dat_q, tx_dat_d;
  logic               rec_active_q, rec_active_d;
  logic [15:0]        drop_q, drop_d;
  logic               hb_pend_q, hb_pend_d;
  logic               banner_q, banner_d;
  logic               last_ovf_q, last_ovf_d;

  logic               tick;
  logic               grant;
  src_e               src;
  logic [FRAME_W-1:0] sel_frame;
  logic               ev_adv;
  logic               tx_start;
  logic [PROBE_W-1:0] ev_probes;
  logic [STAMP_W-1:0] ev_stamp;

  hb_timer #(
    .HB_PERIOD(HB_PERIOD)
  ) u_hb_timer (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign ev_probes = bus.ev_data[STAMP_W +: PROBE_W];
  assign ev_stamp  = bus.ev_data[STAMP_W-1:0];

  // Fixed-priority grant, only while idle and out of reset.
  always_comb begin
    grant = 1'b0;
    src   = SRC_EV;
    if (reset && state_q == IDLE) begin
      if (banner_q) begin
        grant = 1'b1;
        src   = SRC_BANNER;
      end else if (drop_q != 16'd0 && !last_ovf_q) begin
        grant = 1'b1;
        src   = SRC_OVF;
      end else if (hb_pend_q) begin
        grant = 1'b1;
        src   = SRC_HB;
      end else if (bus.ev_valid) begin
        grant = 1'b1;
        src   = SRC_EV;
      end
    end
  end

  // Frame image for the selected source.
  always_comb begin
    sel_frame = BANNER;
    unique case (src)
      SRC_BANNER: sel_frame = BANNER;
      SRC_OVF:    sel_frame = {HDR_OVF, 24'h0, drop_q};
      SRC_HB:     sel_frame = {HDR_HB, 8'h00, stamp};
      SRC_EV:     sel_frame = {HDR_EVENT, ev_probes, ev_stamp};
    endcase
  end

  // Byte sequencer: latch, start, hold, drain per byte.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    frame_d      = frame_q;
    tx_dat_d     = tx_dat_q;
    rec_active_d = rec_active_q;
    ev_adv       = 1'b0;
    tx_start     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          frame_d      = sel_frame;
          idx_d        = 3'd0;
          tx_dat_d     = sel_frame[47:40];
          rec_active_d = 1'b1;
          ev_adv       = (src == SRC_EV);
          state_d      = START;
        end
      end
      START: begin
        tx_start = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        // uart_tx raises busy one cycle after start.
        state_d = DRAIN;
      end
      DRAIN: begin
        if (!bus.tx_busy) begin
          if (idx_q == 3'd5) begin
            rec_active_d = 1'b0;
            state_d      = IDLE;
          end else begin
            idx_d    = idx_q + 3'd1;
            tx_dat_d = frame_byte(frame_q, idx_q + 3'd1);
            state_d  = START;
          end
        end
      end
    endcase
  end

  // Pending-source bookkeeping and drop counter.
  always_comb begin
    banner_d   = banner_q;
    hb_pend_d  = hb_pend_q;
    last_ovf_d = last_ovf_q;
    drop_d     = drop_q;
    if (grant) begin
      last_ovf_d = (src == SRC_OVF);
      if (src == SRC_BANNER) banner_d  = 1'b0;
      if (src == SRC_HB)     hb_pend_d = 1'b0;
    end
    if (tick) hb_pend_d = 1'b1;
    if (grant && src == SRC_OVF) begin
      drop_d = {15'd0, bus.ev_drop};
    end else if (bus.ev_drop && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // State registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      frame_q      <= '0;
      tx_dat_q     <= 8'h00;
      rec_active_q <= 1'b0;
      drop_q       <= 16'd0;
      hb_pend_q    <= 1'b0;
      banner_q     <= 1'b1;
      last_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      tx_dat_q     <= tx_dat_d;
      rec_active_q <= rec_active_d;
      drop_q       <= drop_d;
      hb_pend_q    <= hb_pend_d;
      banner_q     <= banner_d;
      last_ovf_q   <= last_ovf_d;
    end
  end

  assign bus.ev_adv   = ev_adv;
  assign bus.tx_start = tx_start;
  assign bus.tx_dat   = tx_dat_q;
  assign rec_active   = rec_active_q;
  assign drop_count   = drop_q;

endmodule
